// File: rtl/rf_tg_pkg.sv
// rtl/rf_tg_pkg.sv - shared types and data pattern generator for the SRAM traffic generator
package rf_tg_pkg;

  typedef enum logic [1:0] {
    MODE_WRITE_ONLY      = 2'd0,
    MODE_READ_ONLY       = 2'd1,
    MODE_WRITE_THEN_READ = 2'd2,
    MODE_CONCURRENT      = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    PAT_ZEROS     = 2'd0,
    PAT_ONES      = 2'd1,
    PAT_CHECKER   = 2'd2,
    PAT_ADDR_SEED = 2'd3
  } pat_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_CONC  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // Computed at full width; callers truncate to the SRAM word width.
  function automatic logic [63:0] pat_gen(input logic [63:0] addr, input pat_e sel,
                                          input logic [63:0] seed);
    case (sel)
      PAT_ZEROS:   return 64'h0;
      PAT_ONES:    return {64{1'b1}};
      PAT_CHECKER: return addr[0] ? {32{2'b10}} : {32{2'b01}};
      default:     return addr ^ seed;
    endcase
  endfunction

endpackage

// File: rtl/rf_tg_checker.sv
// rtl/rf_tg_checker.sv - read-data pipeline, pattern compare, error counter; RF_TG_ERR_LOG_EN adds first-error log
module rf_tg_checker
  import rf_tg_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int BITS       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  rd_chk,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [BITS-1:0]       qa,
  input  pat_e                  sel,
  input  logic [BITS-1:0]       seed,
  output logic [15:0]           err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [BITS-1:0]       first_err_data
);

  logic                  rd_vld_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [BITS-1:0]       exp_data;
  logic                  mismatch;

  // qa belongs to the read issued one cycle earlier, so compare against the delayed address.
  assign exp_data = BITS'(pat_gen(64'(rd_addr_q), sel, 64'(seed)));
  assign mismatch = rd_vld_q && (qa != exp_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      err_cnt   <= '0;
    end else begin
      rd_vld_q  <= rd_chk;
      rd_addr_q <= rd_addr;
      if (clr) begin
        err_cnt <= '0;
      end else if (mismatch && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end

`ifdef RF_TG_ERR_LOG_EN
  logic err_seen_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_seen_q     <= 1'b0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if (clr) begin
      err_seen_q     <= 1'b0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if (mismatch && !err_seen_q) begin
      err_seen_q     <= 1'b1;
      first_err_addr <= rd_addr_q;
      first_err_data <= qa;
    end
  end
`else
  assign first_err_addr = '0;
  assign first_err_data = '0;
`endif

endmodule

// File: rtl/rf_2p_traffic_gen.sv
// rtl/rf_2p_traffic_gen.sv - two-port SRAM sweep sequencer with read check; RF_TG_ERR_LOG_EN enables first-error log
module rf_2p_traffic_gen
  import rf_tg_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int BITS       = 8,
  parameter int ITER_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            mode,
  input  logic [1:0]            pat_sel,
  input  logic [BITS-1:0]       seed,
  input  logic [ITER_WIDTH-1:0] num_iters,
  output logic                  cena,
  output logic [ADDR_WIDTH-1:0] aa,
  output logic                  cenb,
  output logic [ADDR_WIDTH-1:0] ab,
  output logic [BITS-1:0]       db,
  input  logic [BITS-1:0]       qa,
  output logic                  busy,
  output logic                  done,
  output logic [ITER_WIDTH-1:0] iter_cnt,
  output logic [15:0]           err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [BITS-1:0]       first_err_data
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_HALF = ADDR_WIDTH'(1) << (ADDR_WIDTH - 1);

  state_e                state_q, state_d;
  mode_e                 mode_q;
  pat_e                  sel_q;
  logic [BITS-1:0]       seed_q;
  logic [ITER_WIDTH-1:0] iters_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ITER_WIDTH-1:0] iter_d, iter_inc;
  logic [ADDR_WIDTH-1:0] conc_raddr;
  logic                  cena_d, cenb_d, busy_d, done_d, rd_chk_d, rd_chk_q, start_acc;
  logic [ADDR_WIDTH-1:0] aa_d, ab_d;
  logic [BITS-1:0]       db_d;

  function automatic logic [BITS-1:0] wr_pat(input logic [ADDR_WIDTH-1:0] a, input pat_e s,
                                             input logic [BITS-1:0] sd);
    return BITS'(pat_gen(64'(a), s, 64'(sd)));
  endfunction

  assign iter_inc   = iter_cnt + 1'b1;
  // Read half a memory away from the write so the two ports never hit the same word.
  assign conc_raddr = addr_q + ADDR_HALF;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    iter_d    = iter_cnt;
    cena_d    = 1'b1;
    cenb_d    = 1'b1;
    aa_d      = aa;
    ab_d      = ab;
    db_d      = db;
    rd_chk_d  = 1'b0;
    busy_d    = busy;
    done_d    = 1'b0;
    start_acc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          busy_d    = 1'b1;
          addr_d    = '0;
          iter_d    = '0;
          if (num_iters == '0)                          state_d = S_DONE;
          else if (mode_e'(mode) == MODE_READ_ONLY)     state_d = S_READ;
          else if (mode_e'(mode) == MODE_CONCURRENT)    state_d = S_CONC;
          else                                          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (abort) begin
          state_d = S_DRAIN;
        end else begin
          cenb_d = 1'b0;
          ab_d   = addr_q;
          db_d   = wr_pat(addr_q, sel_q, seed_q);
          addr_d = addr_q + 1'b1;
          if (addr_q == ADDR_LAST) begin
            if (mode_q == MODE_WRITE_THEN_READ) begin
              state_d = S_READ;
            end else begin
              iter_d = iter_inc;
              if (iter_inc == iters_q) state_d = S_DRAIN;
            end
          end
        end
      end
      S_READ: begin
        if (abort) begin
          state_d = S_DRAIN;
        end else begin
          cena_d   = 1'b0;
          aa_d     = addr_q;
          rd_chk_d = 1'b1;
          addr_d   = addr_q + 1'b1;
          if (addr_q == ADDR_LAST) begin
            iter_d = iter_inc;
            if (iter_inc == iters_q)                 state_d = S_DRAIN;
            else if (mode_q == MODE_WRITE_THEN_READ) state_d = S_WRITE;
          end
        end
      end
      S_CONC: begin
        if (abort) begin
          state_d = S_DRAIN;
        end else begin
          cena_d   = 1'b0;
          cenb_d   = 1'b0;
          ab_d     = addr_q;
          db_d     = wr_pat(addr_q, sel_q, seed_q);
          aa_d     = conc_raddr;
          // Skip the upper half on the first sweep: it has not been written yet this run.
          rd_chk_d = (iter_cnt != '0) || (conc_raddr < ADDR_HALF);
          addr_d   = addr_q + 1'b1;
          if (addr_q == ADDR_LAST) begin
            iter_d = iter_inc;
            if (iter_inc == iters_q) state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mode_q   <= MODE_WRITE_ONLY;
      sel_q    <= PAT_ZEROS;
      seed_q   <= '0;
      iters_q  <= '0;
      addr_q   <= '0;
      iter_cnt <= '0;
      cena     <= 1'b1;
      cenb     <= 1'b1;
      aa       <= '0;
      ab       <= '0;
      db       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_chk_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      iter_cnt <= iter_d;
      cena     <= cena_d;
      cenb     <= cenb_d;
      aa       <= aa_d;
      ab       <= ab_d;
      db       <= db_d;
      busy     <= busy_d;
      done     <= done_d;
      rd_chk_q <= rd_chk_d;
      if (start_acc) begin
        mode_q  <= mode_e'(mode);
        sel_q   <= pat_e'(pat_sel);
        seed_q  <= seed;
        iters_q <= num_iters;
      end
    end
  end

  rf_tg_checker #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .BITS      (BITS)
  ) u_checker (
    .clk           (clk),
    .rst           (rst),
    .clr           (start_acc),
    .rd_chk        (rd_chk_q),
    .rd_addr       (aa),
    .qa            (qa),
    .sel           (sel_q),
    .seed          (seed_q),
    .err_cnt       (err_cnt),
    .first_err_addr(first_err_addr),
    .first_err_data(first_err_data)
  );

endmodule

// File: tb/tb_rf_2p_traffic_gen.sv
// tb/tb_rf_2p_traffic_gen.sv - scoreboard bench for rf_2p_traffic_gen with a behavioural SRAM
module tb_rf_2p_traffic_gen;
  localparam int AW = 4;
  localparam int BW = 8;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [1:0]    mode, pat_sel;
  logic [BW-1:0] seed;
  logic [IW-1:0] num_iters;
  logic          cena, cenb, busy, done;
  logic [AW-1:0] aa, ab, first_err_addr;
  logic [BW-1:0] db, qa, first_err_data;
  logic [IW-1:0] iter_cnt;
  logic [15:0]   err_cnt;

  int checks = 0;
  int failures = 0;
  int cyc, done_cnt, done_at, acc_cycles;
  logic busy_at_done;

  logic [BW-1:0]    mem [0:15];
  logic             flip_en = 1'b0;
  logic             flip_all = 1'b0;
  logic [AW-1:0]    flip_addr = '0;
  logic [AW+BW-1:0] wq[$];
  logic [AW-1:0]    rq[$];

  always #5 clk = ~clk;

  rf_2p_traffic_gen #(.ADDR_WIDTH(AW), .BITS(BW), .ITER_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .pat_sel(pat_sel),
    .seed(seed), .num_iters(num_iters), .cena(cena), .aa(aa), .cenb(cenb), .ab(ab), .db(db),
    .qa(qa), .busy(busy), .done(done), .iter_cnt(iter_cnt), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr), .first_err_data(first_err_data)
  );

  always @(posedge clk) begin
    if (cenb === 1'b0) mem[ab] <= db;
    if (cena === 1'b0) qa <= mem[aa] ^ ((flip_all || (flip_en && aa == flip_addr)) ? 8'h01 : 8'h00);
  end

  function automatic logic [BW-1:0] exp_pat(input logic [1:0] p, input logic [AW-1:0] a,
                                            input logic [BW-1:0] s);
    case (p)
      2'd0:    return 8'h00;
      2'd1:    return 8'hFF;
      2'd2:    return a[0] ? 8'hAA : 8'h55;
      default: return {4'h0, a} ^ s;
    endcase
  endfunction

  task automatic push_writes(input logic [1:0] p, input logic [BW-1:0] s, input int cnt);
    for (int a = 0; a < cnt; a++) wq.push_back({AW'(a), exp_pat(p, AW'(a), s)});
  endtask

  task automatic push_reads(input int offset, input int cnt);
    for (int a = 0; a < cnt; a++) rq.push_back(AW'(a + offset));
  endtask

  // Advance to the next falling edge and pop the scoreboard for every access seen.
  task automatic step_cycle();
    logic [AW+BW-1:0] w;
    logic [AW-1:0]    r;
    @(negedge clk);
    cyc++;
    if (done === 1'b1) begin
      done_cnt++;
      if (done_at < 0) done_at = cyc;
      busy_at_done = busy;
    end
    if (cena === 1'b0 || cenb === 1'b0) acc_cycles++;
    if (cena === 1'b0 && cenb === 1'b0) begin
      checks++;
      if (aa === ab) begin failures++; $display("FAIL port_collision aa=%0d ab=%0d", aa, ab); end
    end
    if (cenb === 1'b0) begin
      checks++;
      if (wq.size() == 0) begin
        failures++; $display("FAIL sb_write unexpected ab=%0d db=%h", ab, db);
      end else begin
        w = wq.pop_front();
        if ({ab, db} !== w) begin
          failures++;
          $display("FAIL sb_write got ab=%0d db=%h want ab=%0d db=%h", ab, db, w[AW+BW-1:BW], w[BW-1:0]);
        end
      end
    end
    if (cena === 1'b0) begin
      checks++;
      if (rq.size() == 0) begin
        failures++; $display("FAIL sb_read unexpected aa=%0d", aa);
      end else begin
        r = rq.pop_front();
        if (aa !== r) begin failures++; $display("FAIL sb_read got aa=%0d want aa=%0d", aa, r); end
      end
    end
  endtask

  task automatic launch(input logic [1:0] m, input logic [1:0] p, input logic [BW-1:0] s,
                        input logic [IW-1:0] n);
    mode = m; pat_sel = p; seed = s; num_iters = n; start = 1'b1;
    cyc = -1; done_cnt = 0; done_at = -1; acc_cycles = 0;
    step_cycle();
    start = 1'b0; mode = ~m; pat_sel = ~p; seed = ~s;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin step_cycle(); n++; end
    checks++;
    if (done_cnt == 0) begin failures++; $display("FAIL done_timeout budget=%0d", budget); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step_cycle();
    checks++;
    if ({cena, cenb, busy, done} !== 4'b1100) begin
      failures++; $display("FAIL reset_ctrl got cena,cenb,busy,done=%b want 1100", {cena, cenb, busy, done});
    end
    checks++;
    if ({aa, ab, db} !== '0) begin failures++; $display("FAIL reset_addr got aa=%0d ab=%0d db=%h want 0", aa, ab, db); end
    checks++;
    if (iter_cnt !== 0 || err_cnt !== 0 || first_err_addr !== 0 || first_err_data !== 0) begin
      failures++; $display("FAIL reset_stat got iter=%0d err=%0d fea=%0d fed=%h want 0", iter_cnt, err_cnt, first_err_addr, first_err_data);
    end
    rst = 1'b0;
    abort = 1'b1;
    step_cycle();
    abort = 1'b0;
    step_cycle();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL idle_abort got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_write_then_read();
    for (int it = 0; it < 2; it++) begin push_writes(2'd3, 8'hA5, 16); push_reads(0, 16); end
    launch(2'd2, 2'd3, 8'hA5, 16'd2);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL busy_after_start got %b want 1", busy); end
    repeat (4) step_cycle();
    start = 1'b1; mode = 2'd1;
    step_cycle();
    start = 1'b0;
    wait_done(200);
    checks++;
    if (done_at !== 66) begin failures++; $display("FAIL wtr_done_cycle got %0d want 66", done_at); end
    checks++;
    if (acc_cycles !== 64) begin failures++; $display("FAIL wtr_access_cycles got %0d want 64", acc_cycles); end
    checks++;
    if (iter_cnt !== 2 || err_cnt !== 0) begin failures++; $display("FAIL wtr_counts got iter=%0d err=%0d want 2 0", iter_cnt, err_cnt); end
    checks++;
    if (busy_at_done !== 1'b0) begin failures++; $display("FAIL wtr_busy_at_done got %b want 0", busy_at_done); end
    checks++;
    if (wq.size() != 0 || rq.size() != 0) begin failures++; $display("FAIL wtr_sb_left got w=%0d r=%0d want 0 0", wq.size(), rq.size()); end
    step_cycle();
    checks++;
    if (done !== 1'b0 || iter_cnt !== 2) begin failures++; $display("FAIL wtr_after_done got done=%b iter=%0d want 0 2", done, iter_cnt); end
  endtask

  task automatic test_read_error();
    push_writes(2'd1, 8'h00, 16);
    launch(2'd0, 2'd1, 8'h00, 16'd1);
    wait_done(100);
    checks++;
    if (iter_cnt !== 1 || err_cnt !== 0) begin failures++; $display("FAIL fill_counts got iter=%0d err=%0d want 1 0", iter_cnt, err_cnt); end
    flip_en = 1'b1; flip_addr = 4'd5;
    push_reads(0, 16);
    launch(2'd1, 2'd1, 8'h00, 16'd1);
    wait_done(100);
    checks++;
    if (done_at !== 18) begin failures++; $display("FAIL rderr_done_cycle got %0d want 18", done_at); end
    checks++;
    if (err_cnt !== 1) begin failures++; $display("FAIL rderr_err_cnt got %0d want 1", err_cnt); end
`ifdef RF_TG_ERR_LOG_EN
    checks++;
    if (first_err_addr !== 4'd5 || first_err_data !== 8'hFE) begin
      failures++; $display("FAIL rderr_log got addr=%0d data=%h want 5 fe", first_err_addr, first_err_data);
    end
`else
    checks++;
    if (first_err_addr !== 4'd0 || first_err_data !== 8'h00) begin
      failures++; $display("FAIL rderr_log got addr=%0d data=%h want 0 00", first_err_addr, first_err_data);
    end
`endif
    flip_en = 1'b0;
  endtask

  task automatic test_concurrent();
    for (int pass = 0; pass < 2; pass++) begin
      flip_all = (pass == 1);
      for (int it = 0; it < 3; it++) begin push_writes(2'd2, 8'h00, 16); push_reads(8, 16); end
      launch(2'd3, 2'd2, 8'h00, 16'd3);
      wait_done(200);
      checks++;
      if (done_at !== 50 || acc_cycles !== 48) begin
        failures++; $display("FAIL conc_timing pass=%0d got done=%0d acc=%0d want 50 48", pass, done_at, acc_cycles);
      end
      checks++;
      if (iter_cnt !== 3) begin failures++; $display("FAIL conc_iter pass=%0d got %0d want 3", pass, iter_cnt); end
      checks++;
      if (err_cnt !== ((pass == 1) ? 16'd40 : 16'd0)) begin
        failures++; $display("FAIL conc_err pass=%0d got %0d want %0d", pass, err_cnt, (pass == 1) ? 40 : 0);
      end
    end
    flip_all = 1'b0;
  endtask

  task automatic test_zero_iters();
    launch(2'd0, 2'd0, 8'h00, 16'd0);
    checks++;
    if (done !== 1'b0 || cena !== 1'b1 || cenb !== 1'b1) begin failures++; $display("FAIL zero_c0 got done=%b cena=%b cenb=%b want 0 1 1", done, cena, cenb); end
    step_cycle();
    checks++;
    if (done !== 1'b1 || cena !== 1'b1 || cenb !== 1'b1 || iter_cnt !== 0) begin
      failures++; $display("FAIL zero_c1 got done=%b cena=%b cenb=%b iter=%0d want 1 1 1 0", done, cena, cenb, iter_cnt);
    end
    step_cycle();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL zero_c2 got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_abort();
    push_writes(2'd3, 8'h3C, 7);
    launch(2'd0, 2'd3, 8'h3C, 16'd1);
    repeat (7) step_cycle();
    abort = 1'b1;
    step_cycle();
    abort = 1'b0;
    checks++;
    if (cenb !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL abort_next got cenb=%b busy=%b want 1 1", cenb, busy); end
    wait_done(20);
    checks++;
    if (done_at !== 10 || iter_cnt !== 0 || wq.size() != 0) begin
      failures++; $display("FAIL abort_end got done=%0d iter=%0d left=%0d want 10 0 0", done_at, iter_cnt, wq.size());
    end
    push_writes(2'd0, 8'h00, 15);
    launch(2'd0, 2'd0, 8'h00, 16'd2);
    repeat (15) step_cycle();
    abort = 1'b1;
    step_cycle();
    abort = 1'b0;
    wait_done(20);
    checks++;
    if (done_at !== 18 || iter_cnt !== 0 || wq.size() != 0) begin
      failures++; $display("FAIL abort_last got done=%0d iter=%0d left=%0d want 18 0 0", done_at, iter_cnt, wq.size());
    end
  endtask

  task automatic test_reset_mid_run();
    push_writes(2'd0, 8'h00, 16); push_reads(8, 16);
    launch(2'd3, 2'd0, 8'h00, 16'd1);
    repeat (6) step_cycle();
    rst = 1'b1;
    step_cycle();
    rst = 1'b0;
    checks++;
    if ({busy, cena, cenb, done} !== 4'b0110 || {aa, ab, db} !== '0 || iter_cnt !== 0) begin
      failures++; $display("FAIL rst_mid got busy,cena,cenb,done=%b aa=%0d ab=%0d iter=%0d want 0110 0 0 0", {busy, cena, cenb, done}, aa, ab, iter_cnt);
    end
    wq.delete(); rq.delete();
    repeat (20) step_cycle();
    checks++;
    if (done_cnt !== 0) begin failures++; $display("FAIL rst_no_done got %0d pulses want 0", done_cnt); end
    push_writes(2'd0, 8'h00, 16); push_reads(0, 16);
    launch(2'd2, 2'd0, 8'h00, 16'd1);
    wait_done(100);
    checks++;
    if (done_at !== 34 || iter_cnt !== 1 || err_cnt !== 0 || wq.size() != 0 || rq.size() != 0) begin
      failures++; $display("FAIL rst_rerun got done=%0d iter=%0d err=%0d want 34 1 0", done_at, iter_cnt, err_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = '0; pat_sel = '0; seed = '0; num_iters = '0;
    cyc = 0; done_cnt = 0; done_at = -1; acc_cycles = 0; busy_at_done = 1'b0;
    test_reset();
    test_write_then_read();
    test_read_error();
    test_concurrent();
    test_zero_iters();
    test_abort();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_2p_traffic_gen.md
Name: rf_2p_traffic_gen

Overview:
- Upstream access sequencer that drives the read (A) and write (B) ports of rf_2p_hse_wrapper for SRAM power characterisation.
- Generates programmable write/read sweeps with deterministic data patterns and checks read data against the expected pattern.
- Reports busy, done and error status to the test controller. Both blocks share the single clock `clk`.

Parameters:
- ADDR_WIDTH, `ADDR_WIDTH: SRAM address width; DEPTH = 2**ADDR_WIDTH.
- BITS, `BITS: SRAM word width.
- ITER_WIDTH, 16: width of the iteration count.

Ports:
- clk  in  1  clock, shared with the SRAM wrapper
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; starts a run when idle
- abort  in  1  one-cycle pulse; ends the run early
- mode  in  2  0 WRITE_ONLY, 1 READ_ONLY, 2 WRITE_THEN_READ, 3 CONCURRENT
- pat_sel  in  2  0 zeros, 1 ones, 2 checkerboard, 3 addr^seed
- seed  in  BITS  pattern seed
- num_iters  in  ITER_WIDTH  number of sweeps
- cena  out  1  read enable, active low
- aa  out  ADDR_WIDTH  read address
- cenb  out  1  write enable, active low
- ab  out  ADDR_WIDTH  write address
- db  out  BITS  write data
- qa  in  BITS  read data from the SRAM
- busy  out  1  high while a run is active
- done  out  1  one-cycle pulse at run end
- iter_cnt  out  ITER_WIDTH  sweeps completed
- err_cnt  out  16  saturating count of read mismatches
- first_err_addr  out  ADDR_WIDTH  address of the first mismatch (optional feature)
- first_err_data  out  BITS  qa value at the first mismatch (optional feature)

Behaviour:
- Reset values: cena=1, cenb=1, aa=ab=db=0, busy=0, done=0, iter_cnt=0, err_cnt=0, first_err_*=0; state IDLE.
- All outputs are registered.
- Pattern function pat(a), selected by pat_sel:
  - 0: all zeros; 1: all ones.
  - 2: {BITS/2{2'b01}}, inverted when a[0]=1.
  - 3: a zero-extended to BITS, XOR seed.
  - seed, mode and pat_sel are latched at start.
- FSM states: IDLE, WRITE, READ, CONC, DRAIN, DONE.
- IDLE:
  - start with num_iters=0 goes to DONE.
  - Otherwise start goes to WRITE (modes 0, 2), READ (mode 1) or CONC (mode 3).
  - busy asserts on the cycle after start.
- WRITE: each cycle drives cenb=0, ab=addr, db=pat(addr); addr increments. After addr DEPTH-1 the address wraps to 0, then:
  - mode 2 goes to READ;
  - mode 0 increments iter_cnt and either repeats WRITE or goes to DRAIN.
- READ: each cycle drives cena=0, aa=addr. After addr DEPTH-1, iter_cnt increments, then:
  - mode 1 repeats READ;
  - mode 2 returns to WRITE;
  - when the last iteration completes, the FSM goes to DRAIN.
- CONC: same cycle drives write ab=addr and read aa=(addr+DEPTH/2) mod DEPTH. The two ports never collide.
  - The read is compared only when the iteration index > 0 or the address is < DEPTH/2, so that the location was written earlier in the run.
- Read latency: qa is valid the cycle after cena=0. A 1-stage pipeline (rd_vld_q, rd_addr_q) compares qa against pat(rd_addr_q).
  - On mismatch, err_cnt increments, saturating at 16'hFFFF.
- DRAIN: one cycle with cena=cenb=1; the last read compare completes. Then DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE. err_cnt and iter_cnt hold until the next start, which clears them.
- abort in any active state: on the next edge cena=cenb=1 and the FSM goes to DRAIN. The outstanding compare still counts.
- start while busy is ignored. abort while IDLE is ignored. If abort and the last-address completion coincide, abort wins, so iter_cnt does not increment.
- rst mid-run: on the next edge all outputs return to reset values and no done pulse is generated.

Optional Feature:
- Macro RF_TG_ERR_LOG_EN.
- Defined: first_err_addr/first_err_data capture the first mismatch since start, then hold.
- Undefined: both outputs are tied to 0 and no capture registers are synthesised.

Decomposition:
- Package rf_tg_pkg holds:
  - mode_e and pat_e enums;
  - state_e enum;
  - pure function pat_gen(addr, sel, seed).
- One sub-module is natural: rf_tg_checker, holding the read pipeline, compare, err_cnt and the optional error log.

Test Plan:
All scenarios use ADDR_WIDTH=4, BITS=8 and a behavioural model of the SRAM.
- Mode 2, pat_sel 3, seed 8'hA5, num_iters 2 → 64 access cycles; the first write has ab=0, db=8'hA5; done after DRAIN; iter_cnt=2, err_cnt=0.
- Mode 1 after the SRAM model injects a flipped bit 0 at addr 5 (pat_sel 1) → err_cnt=1; first_err_addr=5, first_err_data=8'hFE with the macro, 0 without.
- Mode 3, pat_sel 2, num_iters 3 → never aa==ab on any cycle; 40 compares (8+16+16); err_cnt=0.
- num_iters=0 → done pulses 2 cycles after start; cena/cenb stay 1.
- abort at cycle 7 of a mode 0 run → cenb=1 next cycle; done 2 cycles later; iter_cnt=0.
- rst asserted mid-CONC → next cycle busy=0, cena=cenb=1; no done pulse; a fresh start runs normally.
